count_mod11_checker: RTL and testbench
======================================

Name: count_mod11_checker

Overview:
- Synthesizable in-line checker that listens to both sides of the mod-11 loadable up/down counter interface.
- Watches the stimulus side (din, load, up_down, DUT resetn) and predicts the counter value with its own reference model.
- Compares the prediction against the DUT count every cycle and reports mismatches through sticky flags, counters and first-failure capture.
- Sits beside the counter DUT, in the FPGA-level or emulation build, where no SV bench is present.

Parameters:
- MODULUS, 11, counter modulus; legal range 2..16; count values run 0..MODULUS-1.
- ERR_W, 8, width of the saturating mismatch counter.
- CHK_W, 16, width of the saturating compare counter.
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch.

Ports:
- clock  in  1  single clock; every signal is sampled on posedge.
- resetn  in  1  checker reset; asynchronous, active-low.
- enable  in  1  checker active.
- clear_stats  in  1  synchronous clear of statistics.
- dut_resetn  in  1  DUT's synchronous active-low reset, as driven to the DUT.
- din  in  4  DUT load data.
- load  in  1  DUT load strobe.
- up_down  in  1  DUT direction; 1 = up, 0 = down.
- count  in  4  DUT registered count output.
- in_sync  out  1  high while state = CHECK.
- mismatch  out  1  one-cycle pulse, registered.
- illegal_load  out  1  one-cycle pulse; load sampled with din >= MODULUS.
- error  out  1  sticky; set on any mismatch.
- err_count  out  ERR_W  saturating mismatch count.
- chk_count  out  CHK_W  saturating count of compares performed.
- first_exp  out  4  expected value at the first mismatch.
- first_act  out  4  actual value at the first mismatch.

Behaviour:
- Reset (resetn=0, async):
  - state = UNSYNC; exp_q = 0.
  - All outputs 0; first_exp and first_act = 0.
- States: UNSYNC, CHECK, HALT. Only edges with enable=1 act.
- enable=0 at an edge: no compare and no stat update; state -> UNSYNC.
- Reference model, evaluated at edge k on sampled inputs. Priority: dut_resetn=0 > load > count.
  - dut_resetn=0: next = 0.
  - load=1, din < MODULUS: next = din.
  - load=1, din >= MODULUS: illegal_load pulses next cycle; state -> UNSYNC (prediction undefined).
  - up_down=1: next = exp_q + 1; MODULUS-1 wraps to 0.
  - up_down=0: next = exp_q - 1; 0 wraps to MODULUS-1.
- UNSYNC:
  - dut_resetn=0 or legal load: exp_q <= next; state -> CHECK.
  - Otherwise hold.
- CHECK, at each edge:
  - Compare sampled count with exp_q. A count >= MODULUS is always a mismatch.
  - chk_count++ (saturating at all-ones).
  - On mismatch:
    - mismatch pulses next cycle; error <= 1; err_count++ (saturating at all-ones).
    - If error was 0 before this edge, capture first_exp = exp_q and first_act = count.
  - exp_q <= next, so one cycle of latency between DUT edge and compare.
  - Mismatch with STOP_ON_ERR=1: state -> HALT, exp_q frozen.
  - Illegal load overrides the above: compare still done this edge, then state -> UNSYNC.
  - Mismatch with STOP_ON_ERR=0: keep tracking from exp_q; no resync on mismatch.
- HALT:
  - No compares, exp_q frozen, stats held.
  - clear_stats=1 -> UNSYNC.
- clear_stats (any state):
  - Zeroes error, err_count, chk_count, first_exp, first_act at that edge.
  - A compare on the same edge is applied after the clear: e.g. mismatch gives err_count=1, error=1 and a fresh capture.
- dut_resetn=0 in CHECK: the compare of that edge still happens, then exp_q <= 0.
- Widths: internal arithmetic on 4 bits, with an explicit wrap compare against MODULUS-1 (no natural overflow).

Test Plan:
- Reset release; dut_resetn low for 1 cycle, then up_down=1 for 12 cycles with the DUT correct -> in_sync=1; exp sequence 0..10,0,1; error=0; chk_count=12.
- Load din=3, up_down=0 for 5 cycles -> exp 3,2,1,0,10,9; no mismatch.
- Force DUT count=7 when exp=5, STOP_ON_ERR=0 -> mismatch pulses 1 cycle; error=1; err_count=1; first_exp=5, first_act=7; a later second fault gives err_count=2 with capture unchanged.
- load with din=12 -> illegal_load pulse; in_sync=0; no compares until the next legal load or dut_resetn.
- STOP_ON_ERR=1 with a fault -> HALT, chk_count frozen; clear_stats -> all stats 0, UNSYNC; legal load resyncs.
- ERR_W=2, 5 faults -> err_count saturates at 3. Asserting resetn mid-CHECK -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_mod11_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_mod11_checker
// Purpose  : In-line checker for a loadable mod-MODULUS up/down counter.
//            Snoops the counter's stimulus (dut_resetn, load, din, up_down),
//            predicts the counter value with a reference model and compares
//            it against the counter's registered count every cycle. It
//            reports results through pulses, sticky flags, saturating
//            counters and a first-failure capture.
// Ports    : clock        - sampling clock (posedge)
//            resetn       - checker reset, asynchronous, active-low
//            enable       - checker active; low forces UNSYNC, freezes stats
//            clear_stats  - synchronous clear of all statistics
//            dut_resetn   - counter's synchronous active-low reset
//            din/load     - counter load data / load strobe
//            up_down      - counter direction (1 = up)
//            count        - counter registered output under test
//            in_sync      - high while tracking (CHECK state)
//            mismatch     - one-cycle pulse per failed compare
//            illegal_load - one-cycle pulse when load sees din >= MODULUS
//            error        - sticky mismatch flag
//            err_count    - saturating mismatch count
//            chk_count    - saturating compare count
//            first_exp    - expected value at the first mismatch
//            first_act    - observed value at the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module count_mod11_checker #(
   parameter int MODULUS     = 11,
   parameter int ERR_W       = 8,
   parameter int CHK_W       = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             enable,
   input  logic             clear_stats,
   input  logic             dut_resetn,
   input  logic [3:0]       din,
   input  logic             load,
   input  logic             up_down,
   input  logic [3:0]       count,
   output logic             in_sync,
   output logic             mismatch,
   output logic             illegal_load,
   output logic             error,
   output logic [ERR_W-1:0] err_count,
   output logic [CHK_W-1:0] chk_count,
   output logic [3:0]       first_exp,
   output logic [3:0]       first_act
);

   localparam logic [1:0] c_UNSYNC  = 2'd0;
   localparam logic [1:0] c_CHECK   = 2'd1;
   localparam logic [1:0] c_HALT    = 2'd2;

   // 5-bit modulus so that MODULUS = 16 still compares correctly with 4-bit data
   localparam logic [4:0] c_MOD5    = 5'(MODULUS);
   localparam logic [3:0] c_MAX_VAL = 4'(MODULUS - 1);

   logic [1:0]       r_state;
   logic [3:0]       r_exp;
   logic             r_mismatch;
   logic             r_illegal;
   logic             r_error;
   logic [ERR_W-1:0] r_err_count;
   logic [CHK_W-1:0] r_chk_count;
   logic [3:0]       r_first_exp;
   logic [3:0]       r_first_act;

   logic             w_illegal;
   logic             w_resync;
   logic             w_mis;
   logic             w_cmp;
   logic             w_hit;
   logic             w_capture;
   logic [3:0]       w_inc;
   logic [3:0]       w_dec;
   logic [3:0]       w_next;
   logic             w_err_base;
   logic [ERR_W-1:0] w_errc_base;
   logic [CHK_W-1:0] w_chk_base;
   logic [3:0]       w_fe_base;
   logic [3:0]       w_fa_base;

   // Reference model and compare
   always_comb begin
      // Explicit wrap compares: 4-bit arithmetic must never rely on overflow
      w_inc     = (r_exp == c_MAX_VAL) ? 4'd0 : r_exp + 4'd1;
      w_dec     = (r_exp == 4'd0) ? c_MAX_VAL : r_exp - 4'd1;
      // dut_resetn outranks load, so a load under reset is never illegal
      w_illegal = dut_resetn && load && ({1'b0, din} >= c_MOD5);
      w_resync  = !dut_resetn || (load && !w_illegal);
      if (!dut_resetn) begin
         w_next = 4'd0;
      end else if (load) begin
         w_next = din;
      end else if (up_down) begin
         w_next = w_inc;
      end else begin
         w_next = w_dec;
      end
      // An out-of-range count is a mismatch even if r_exp were corrupted
      w_mis     = ({1'b0, count} >= c_MOD5) || (count != r_exp);
      w_cmp     = enable && (r_state == c_CHECK);
      w_hit     = w_cmp && w_mis;
   end

   // Statistics: clear is applied first, so a same-edge compare lands on
   // freshly zeroed stats (including a new first-failure capture)
   always_comb begin
      w_err_base  = clear_stats ? 1'b0 : r_error;
      w_errc_base = clear_stats ? '0 : r_err_count;
      w_chk_base  = clear_stats ? '0 : r_chk_count;
      w_fe_base   = clear_stats ? 4'd0 : r_first_exp;
      w_fa_base   = clear_stats ? 4'd0 : r_first_act;
      w_capture   = w_hit && !w_err_base;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= c_UNSYNC;
         r_exp       <= 4'd0;
         r_mismatch  <= 1'b0;
         r_illegal   <= 1'b0;
         r_error     <= 1'b0;
         r_err_count <= '0;
         r_chk_count <= '0;
         r_first_exp <= 4'd0;
         r_first_act <= 4'd0;
      end else if (!enable) begin
         // Disabled edges drop tracking but leave statistics untouched
         r_state    <= c_UNSYNC;
         r_mismatch <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_mismatch  <= w_hit;
         r_illegal   <= w_illegal;
         r_error     <= w_err_base | w_hit;
         r_err_count <= (w_hit && (w_errc_base != '1)) ?
                        w_errc_base + ERR_W'(1) : w_errc_base;
         r_chk_count <= (w_cmp && (w_chk_base != '1)) ?
                        w_chk_base + CHK_W'(1) : w_chk_base;
         r_first_exp <= w_capture ? r_exp : w_fe_base;
         r_first_act <= w_capture ? count : w_fa_base;

         case (r_state)
            c_UNSYNC: begin
               if (w_resync) begin
                  r_exp   <= w_next;
                  r_state <= c_CHECK;
               end
            end
            c_CHECK: begin
               // Illegal load makes the prediction meaningless: drop sync
               if (w_illegal) begin
                  r_state <= c_UNSYNC;
               end else if (w_mis && STOP_ON_ERR) begin
                  r_state <= c_HALT;
               end else begin
                  r_exp <= w_next;
               end
            end
            c_HALT: begin
               if (clear_stats) begin
                  r_state <= c_UNSYNC;
               end
            end
            default: begin
               r_state <= c_UNSYNC;
            end
         endcase
      end
   end

   assign in_sync      = (r_state == c_CHECK);
   assign mismatch     = r_mismatch;
   assign illegal_load = r_illegal;
   assign error        = r_error;
   assign err_count    = r_err_count;
   assign chk_count    = r_chk_count;
   assign first_exp    = r_first_exp;
   assign first_act    = r_first_act;

endmodule
`default_nettype wire

// File: tb/tb_count_mod11_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_mod11_checker
// Purpose  : Self-checking bench for count_mod11_checker. Three checker
//            instances (default, STOP_ON_ERR=1, ERR_W=2) share one stimulus
//            stream. A behavioural counter produces the snooped count, with
//            optional fault values; a behavioural checker model predicts all
//            outputs; literal expectations pin key points of the scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_mod11_checker;

   localparam int MOD = 11;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b1;
   logic       clear_stats = 1'b0;
   logic       dut_resetn = 1'b1;
   logic [3:0] din = 4'd0;
   logic       load = 1'b0;
   logic       up_down = 1'b1;
   logic [3:0] count = 4'd0;

   logic        in_sync_w [3];
   logic        mis_w     [3];
   logic        ill_w     [3];
   logic        err_w     [3];
   logic [15:0] chk_w     [3];
   logic [3:0]  fe_w      [3];
   logic [3:0]  fa_w      [3];
   logic [7:0]  errc_w0;
   logic [7:0]  errc_w1;
   logic [1:0]  errc_w2;

   int n_chk = 0;
   int n_err = 0;
   int ctr   = 0;   // behavioural counter driving 'count'

   // Checker model: 0 = unsynced, 1 = tracking, 2 = halted
   int m_st [3], m_exp [3], m_mis [3], m_ill [3], m_err [3];
   int m_errc [3], m_chkc [3], m_fe [3], m_fa [3];

   always #5 clock = ~clock;

   count_mod11_checker #(.MODULUS(11), .ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b0)) u_dut0 (
      .clock(clock), .resetn(resetn), .enable(enable), .clear_stats(clear_stats),
      .dut_resetn(dut_resetn), .din(din), .load(load), .up_down(up_down), .count(count),
      .in_sync(in_sync_w[0]), .mismatch(mis_w[0]), .illegal_load(ill_w[0]), .error(err_w[0]),
      .err_count(errc_w0), .chk_count(chk_w[0]), .first_exp(fe_w[0]), .first_act(fa_w[0]));

   count_mod11_checker #(.MODULUS(11), .ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b1)) u_dut1 (
      .clock(clock), .resetn(resetn), .enable(enable), .clear_stats(clear_stats),
      .dut_resetn(dut_resetn), .din(din), .load(load), .up_down(up_down), .count(count),
      .in_sync(in_sync_w[1]), .mismatch(mis_w[1]), .illegal_load(ill_w[1]), .error(err_w[1]),
      .err_count(errc_w1), .chk_count(chk_w[1]), .first_exp(fe_w[1]), .first_act(fa_w[1]));

   count_mod11_checker #(.MODULUS(11), .ERR_W(2), .CHK_W(16), .STOP_ON_ERR(1'b0)) u_dut2 (
      .clock(clock), .resetn(resetn), .enable(enable), .clear_stats(clear_stats),
      .dut_resetn(dut_resetn), .din(din), .load(load), .up_down(up_down), .count(count),
      .in_sync(in_sync_w[2]), .mismatch(mis_w[2]), .illegal_load(ill_w[2]), .error(err_w[2]),
      .err_count(errc_w2), .chk_count(chk_w[2]), .first_exp(fe_w[2]), .first_act(fa_w[2]));

   function automatic int errc_of(input int i);
      if (i == 0) return int'(errc_w0);
      if (i == 1) return int'(errc_w1);
      return int'(errc_w2);
   endfunction

   function automatic int errmax(input int i);
      return (i == 2) ? 3 : 255;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_exp[i] = 0; m_mis[i] = 0; m_ill[i] = 0; m_err[i] = 0;
         m_errc[i] = 0; m_chkc[i] = 0; m_fe[i] = 0; m_fa[i] = 0;
      end
   endtask

   // One clock edge of the checker, from the rules in plain arithmetic
   task automatic model_edge(input int i);
      int  nxt;
      bit  ill;
      bit  bad;
      if (!enable) begin
         m_st[i] = 0; m_mis[i] = 0; m_ill[i] = 0;
         return;
      end
      ill = dut_resetn && load && (int'(din) >= MOD);
      if (!dut_resetn)  nxt = 0;
      else if (load)    nxt = int'(din);
      else if (up_down) nxt = (m_exp[i] + 1) % MOD;
      else              nxt = (m_exp[i] + MOD - 1) % MOD;
      m_ill[i] = ill;
      m_mis[i] = 0;
      if (clear_stats) begin
         m_err[i] = 0; m_errc[i] = 0; m_chkc[i] = 0; m_fe[i] = 0; m_fa[i] = 0;
      end
      if (m_st[i] == 0) begin
         if (!dut_resetn || (load && !ill)) begin
            m_exp[i] = nxt;
            m_st[i]  = 1;
         end
      end else if (m_st[i] == 1) begin
         bad = (int'(count) >= MOD) || (int'(count) != m_exp[i]);
         if (m_chkc[i] < 65535) m_chkc[i]++;
         if (bad) begin
            m_mis[i] = 1;
            if (m_err[i] == 0) begin
               m_fe[i] = m_exp[i];
               m_fa[i] = int'(count);
            end
            m_err[i] = 1;
            if (m_errc[i] < errmax(i)) m_errc[i]++;
         end
         if (ill)                m_st[i] = 0;
         else if (bad && i == 1) m_st[i] = 2;
         else                    m_exp[i] = nxt;
      end else begin
         if (clear_stats) m_st[i] = 0;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         chk("in_sync",      i, int'(in_sync_w[i]), (m_st[i] == 1) ? 1 : 0);
         chk("mismatch",     i, int'(mis_w[i]),     m_mis[i]);
         chk("illegal_load", i, int'(ill_w[i]),     m_ill[i]);
         chk("error",        i, int'(err_w[i]),     m_err[i]);
         chk("err_count",    i, errc_of(i),         m_errc[i]);
         chk("chk_count",    i, int'(chk_w[i]),     m_chkc[i]);
         chk("first_exp",    i, int'(fe_w[i]),      m_fe[i]);
         chk("first_act",    i, int'(fa_w[i]),      m_fa[i]);
      end
   endtask

   // One cycle: compare at negedge, drive inputs, advance models after posedge.
   // fval >= 0 presents that value on count instead of the correct counter.
   task automatic cyc(input logic dr, input logic ld, input int d, input logic ud,
                      input int fval = -1);
      @(negedge clock);
      compare_all();
      dut_resetn = dr;
      load       = ld;
      din        = 4'(d);
      up_down    = ud;
      count      = (fval >= 0) ? 4'(fval) : 4'(ctr);
      @(posedge clock);
      #1;
      if (resetn) begin
         for (int i = 0; i < 3; i++) model_edge(i);
      end
      if (!dr)          ctr = 0;
      else if (ld)      ctr = (d < MOD) ? d : ctr;
      else if (ud)      ctr = (ctr + 1) % MOD;
      else              ctr = (ctr + MOD - 1) % MOD;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_down [5] = '{2, 1, 0, 10, 9};
      model_reset();

      // Reset state
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("reset_error", 0, int'(err_w[0]), 0);
      resetn = 1'b1;

      // Sync via dut_resetn, then count up through the wrap
      cyc(0, 0, 0, 1);
      for (int k = 0; k < 12; k++) begin
         chk("model_exp_up", 0, m_exp[0], k % 11);
         cyc(1, 0, 0, 1);
      end
      chk("lit_in_sync", 0, int'(in_sync_w[0]), 1);
      chk("lit_chk12",   0, int'(chk_w[0]), 12);
      chk("lit_noerr",   0, int'(err_w[0]), 0);
      chk("model_exp1",  0, m_exp[0], 1);

      // Load 3, count down through the wrap
      cyc(1, 1, 3, 0);
      chk("model_exp3", 0, m_exp[0], 3);
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 0, 0);
         chk("model_exp_down", 0, m_exp[0], exp_down[k]);
      end
      chk("lit_noerr_down", 0, int'(err_w[0]), 0);
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
      chk("model_exp5", 0, m_exp[0], 5);

      // Fault: count 7 while 5 is expected
      cyc(1, 0, 0, 0, 7);
      chk("lit_mis_pulse", 0, int'(mis_w[0]), 1);
      chk("lit_error",     0, int'(err_w[0]), 1);
      chk("lit_errc1",     0, int'(errc_w0), 1);
      chk("lit_first_exp", 0, int'(fe_w[0]), 5);
      chk("lit_first_act", 0, int'(fa_w[0]), 7);
      chk("lit_chk23",     0, int'(chk_w[0]), 23);
      chk("lit_halt_sync", 1, int'(in_sync_w[1]), 0);
      cyc(1, 0, 0, 0);
      chk("lit_mis_end",   0, int'(mis_w[0]), 0);
      chk("lit_halt_chk",  1, int'(chk_w[1]), 23);
      cyc(1, 0, 0, 0, 15);
      chk("lit_errc2",     0, int'(errc_w0), 2);
      chk("lit_keep_fe",   0, int'(fe_w[0]), 5);
      chk("lit_keep_fa",   0, int'(fa_w[0]), 7);

      // Illegal load
      cyc(1, 1, 12, 0);
      chk("lit_illegal", 0, int'(ill_w[0]), 1);
      chk("lit_unsync",  0, int'(in_sync_w[0]), 0);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1);
      chk("lit_no_cmp",  0, int'(chk_w[0]), 26);
      cyc(1, 1, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);

      // clear_stats releases HALT; legal load resyncs
      clear_stats = 1'b1;
      cyc(1, 0, 0, 1);
      clear_stats = 1'b0;
      chk("lit_clr_chk",   0, int'(chk_w[0]), 1);
      chk("lit_clr_errc",  1, int'(errc_w1), 0);
      chk("lit_clr_chk1",  1, int'(chk_w[1]), 0);
      chk("lit_clr_err1",  1, int'(err_w[1]), 0);
      chk("lit_clr_unsync",1, int'(in_sync_w[1]), 0);
      cyc(1, 1, 6, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("lit_resync1",   1, int'(in_sync_w[1]), 1);
      chk("lit_chk1_2",    1, int'(chk_w[1]), 2);

      // clear_stats together with a mismatch, then saturation
      clear_stats = 1'b1;
      cyc(1, 0, 0, 1, 15);
      clear_stats = 1'b0;
      chk("lit_cm_errc",   0, int'(errc_w0), 1);
      chk("lit_cm_fe",     0, int'(fe_w[0]), 8);
      chk("lit_cm_fa",     0, int'(fa_w[0]), 15);
      chk("lit_cm_chk",    0, int'(chk_w[0]), 1);
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 15);
      chk("lit_errc5",     0, int'(errc_w0), 5);
      chk("lit_sat3",      2, int'(errc_w2), 3);

      // enable low drops sync, stats held
      enable = 1'b0;
      cyc(1, 0, 0, 1);
      enable = 1'b1;
      chk("lit_dis_sync",  0, int'(in_sync_w[0]), 0);
      chk("lit_dis_chk",   0, int'(chk_w[0]), 5);

      // Resync, then dut_resetn while tracking
      cyc(0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("model_exp_dr", 0, m_exp[0], 1);

      // Asynchronous reset between edges
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("lit_async_sync", 0, int'(in_sync_w[0]), 0);
      chk("lit_async_err",  0, int'(err_w[0]), 0);
      chk("lit_async_errc", 0, int'(errc_w0), 0);
      chk("lit_async_chk",  0, int'(chk_w[0]), 0);
      cyc(1, 0, 0, 1);
      resetn = 1'b1;
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      @(negedge clock);
      compare_all();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
